// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its queue.
package instruction_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [1:0] QUEUE_DEPTH = 2'd2;

endpackage

// File: rtl/instruction_fetch_sequencer_fetch_skid_buffer.sv
// Two-entry registered FIFO between the fetch engine and decode; slot 0 is the head.
module fetch_skid_buffer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int Width = 39
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [Width-1:0] head_data,
  output logic [1:0]       count
);

  logic [Width-1:0] slot_q [2];
  logic [Width-1:0] slot_d [2];
  logic [1:0]       count_q, count_d;
  logic             pop_eff;

  assign pop_eff = pop && (count_q != 2'd0);

  always_comb begin
    slot_d[0] = slot_q[0];
    slot_d[1] = slot_q[1];
    count_d   = count_q;
    if (flush) begin
      // Flush wins over push; a same-cycle pop of the head has already been taken by decode.
      count_d = 2'd0;
    end else begin
      case ({push, pop_eff})
        2'b01: begin
          slot_d[0] = slot_q[1];
          count_d   = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) slot_d[0] = push_data;
          else                 slot_d[1] = push_data;
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot_d[0] = push_data;
          end else begin
            slot_d[0] = slot_q[1];
            slot_d[1] = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      count_q   <= 2'd0;
    end else if (en) begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      count_q   <= count_d;
    end
  end

  assign valid     = (count_q != 2'd0);
  assign head_data = slot_q[0];
  assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// PC register, request FSM and free-slot logic feeding the decode-side fetch queue.
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int                AddrBits    = 7,
  parameter int                InstrBits   = 32,
  parameter logic [AddrBits-1:0] ResetVector = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clock_enable,
  input  logic                 branch_valid,
  input  logic [AddrBits-1:0]  branch_address,
  input  logic                 halt,
  output logic                 imem_req,
  output logic [AddrBits-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [InstrBits-1:0] imem_data,
  output logic                 fetch_valid,
  input  logic                 fetch_ready,
  output logic [AddrBits-1:0]  fetch_pc,
  output logic [InstrBits-1:0] fetch_instr,
  output logic                 busy
);

  fetch_state_e        state_q, state_d;
  logic [AddrBits-1:0] pc_q, pc_d;
  logic [AddrBits-1:0] addr_q, addr_d;
  logic                req_q, req_d;
  logic [1:0]          count;
  logic                push, pop, room_after;

  assign pop  = fetch_valid && fetch_ready;
  assign push = (state_q == REQ) && imem_ack && !branch_valid;
  // A redirect flushes the queue, so both slots are free for the new path.
  assign room_after = branch_valid || ((count + 2'd1 - {1'b0, pop}) < QUEUE_DEPTH);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (state_q == REQ && imem_ack) pc_d = pc_q + 1'b1;
    if (branch_valid)               pc_d = branch_address;
    case (state_q)
      IDLE: begin
        if (!halt && (branch_valid || count < QUEUE_DEPTH)) state_d = REQ;
      end
      REQ: begin
        if (imem_ack)          state_d = (!halt && room_after) ? REQ : IDLE;
        else if (branch_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (imem_ack) state_d = halt ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d != IDLE);
    // A request that is still waiting (REQ or DRAIN) keeps its address.
    addr_d = (state_d == REQ) ? pc_d : addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= ResetVector;
      addr_q  <= ResetVector;
      req_q   <= 1'b0;
    end else if (clock_enable) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  fetch_skid_buffer #(
    .Width(AddrBits + InstrBits)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (clock_enable),
    .flush    (branch_valid),
    .push     (push),
    .push_data({addr_q, imem_data}),
    .pop      (fetch_ready),
    .valid    (fetch_valid),
    .head_data({fetch_pc, fetch_instr}),
    .count    (count)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign busy      = req_q | fetch_valid;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed and randomized bench for the fetch sequencer against a transaction-level model.
module tb_instruction_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clock_enable = 1'b0;
  logic        branch_valid = 1'b0;
  logic [6:0]  branch_address = '0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [6:0]  fetch_pc;
  logic [31:0] fetch_instr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  instruction_fetch_sequencer #(
    .AddrBits   (7),
    .InstrBits  (32),
    .ResetVector(7'd0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clock_enable  (clock_enable),
    .branch_valid  (branch_valid),
    .branch_address(branch_address),
    .halt          (halt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_pc      (fetch_pc),
    .fetch_instr   (fetch_instr),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding memory request plus an ordered queue toward decode.
  typedef struct packed {
    logic [6:0]  pc;
    logic [31:0] instr;
  } entry_t;

  entry_t     mq[$];
  logic [6:0] m_pc;
  logic [6:0] m_addr;
  bit         m_out;
  bit         m_wrong_path;

  task automatic model_reset();
    mq.delete();
    m_pc         = 7'd0;
    m_addr       = 7'd0;
    m_out        = 1'b0;
    m_wrong_path = 1'b0;
  endtask

  task automatic model_update(input bit br, input logic [6:0] ba, input bit h,
                              input bit ack, input logic [31:0] data, input bit rdy);
    int  n_before;
    bit  completed, useful, start;
    n_before  = mq.size();
    completed = m_out && ack;
    useful    = completed && !m_wrong_path && !br;
    if (br) begin
      mq.delete();
    end else begin
      if (rdy && n_before > 0) void'(mq.pop_front());
      if (useful) mq.push_back('{pc: m_addr, instr: data});
    end
    if (completed && !m_wrong_path) m_pc = m_pc + 7'd1;
    if (br) m_pc = ba;
    if (m_out && !ack) begin
      if (br) m_wrong_path = 1'b1;
    end else begin
      if (!m_out)            start = !h && (br || n_before < 2);
      else if (m_wrong_path) start = !h;
      else                   start = !h && (br || mq.size() < 2);
      m_wrong_path = 1'b0;
      m_out        = start;
      if (start) m_addr = m_pc;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", {63'd0, imem_req}, {63'd0, m_out});
    chk("imem_addr", {57'd0, imem_addr}, {57'd0, m_addr});
    chk("fetch_valid", {63'd0, fetch_valid}, {63'd0, (mq.size() > 0)});
    if (mq.size() > 0) begin
      chk("fetch_pc", {57'd0, fetch_pc}, {57'd0, mq[0].pc});
      chk("fetch_instr", {32'd0, fetch_instr}, {32'd0, mq[0].instr});
    end
    chk("busy", {63'd0, busy}, {63'd0, (m_out || mq.size() > 0)});
  endtask

  task automatic check_reset_values();
    check_outputs();
    chk("reset_fetch_pc", {57'd0, fetch_pc}, 64'd0);
    chk("reset_fetch_instr", {32'd0, fetch_instr}, 64'd0);
  endtask

  // Starts and ends at a falling edge; the model advances on each enabled rising edge.
  task automatic cyc(input bit en, input bit br, input logic [6:0] ba,
                     input bit h, input bit ack, input bit rdy);
    check_outputs();
    clock_enable   = en;
    branch_valid   = br;
    branch_address = ba;
    halt           = h;
    imem_ack       = ack && m_out;
    imem_data      = $urandom;
    fetch_ready    = rdy;
    @(posedge clk);
    if (en) model_update(br, ba, h, imem_ack, imem_data, rdy);
    @(negedge clk);
  endtask

  task automatic inputs_idle();
    clock_enable = 1'b1;
    branch_valid = 1'b0;
    halt         = 1'b0;
    imem_ack     = 1'b0;
    fetch_ready  = 1'b0;
  endtask

  task automatic power_on_reset();
    inputs_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    inputs_idle();
    model_reset();
    #1;
    check_reset_values();
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
  endtask

  initial begin
    power_on_reset();
    // Streaming: ack every cycle, decode always ready.
    repeat (8) cyc(1, 0, 7'd0, 0, 1, 1);
    // Backpressure: only two requests before the queue fills.
    repeat (6) cyc(1, 0, 7'd0, 0, 1, 0);
    repeat (4) cyc(1, 0, 7'd0, 0, 1, 1);
    // Redirect while the request to address 5 is still pending.
    cyc(1, 1, 7'h05, 0, 1, 1);
    cyc(1, 0, 7'd0, 0, 0, 1);
    cyc(1, 1, 7'h40, 0, 0, 1);
    repeat (3) cyc(1, 0, 7'd0, 0, 0, 1);
    repeat (5) cyc(1, 0, 7'd0, 0, 1, 1);
    // Redirect coinciding with an ack and a decode handshake.
    cyc(1, 0, 7'd0, 0, 1, 0);
    cyc(1, 1, 7'h10, 0, 1, 1);
    repeat (4) cyc(1, 0, 7'd0, 0, 1, 1);
    // PC wrap-around at the top of the address space.
    cyc(1, 1, 7'h7E, 0, 1, 1);
    repeat (5) cyc(1, 0, 7'd0, 0, 1, 1);
    // Halt with a request outstanding.
    repeat (2) cyc(1, 0, 7'd0, 1, 0, 0);
    cyc(1, 0, 7'd0, 1, 1, 0);
    repeat (3) cyc(1, 0, 7'd0, 1, 1, 1);
    repeat (3) cyc(1, 0, 7'd0, 0, 1, 1);
    // Clock enable low freezes everything.
    repeat (4) cyc(0, ($urandom_range(1) == 1), 7'($urandom_range(127)), 0, 1, 1);
    repeat (3) cyc(1, 0, 7'd0, 0, 1, 0);
    async_reset();
    repeat (4) cyc(1, 0, 7'd0, 0, 1, 1);
    // Randomized traffic.
    repeat (3000) begin
      cyc(($urandom_range(7) != 0), ($urandom_range(15) == 0), 7'($urandom_range(127)),
          ($urandom_range(5) == 0), ($urandom_range(2) != 0), ($urandom_range(3) != 0));
    end
    check_outputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
